// File: rtl/pe_tensor_mc.sv
`timescale 1ns/1ps
// Tensor PE: multiplies a KxK ifmap window by the current channel's filter, reduces the
// products and accumulates across NUM_CH channels, emitting one psum per group over valid/ready.
module pe_tensor_mc #(
    parameter int DATA_W   = 8,
    parameter int K        = 3,
    parameter int NUM_CH   = 4,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 16,
    parameter bit SATURATE = 1'b1,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int TAPS    = K * K
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_write_en,
    input  logic [CH_W-1:0]          wb_addr,
    input  logic [TAPS*DATA_W-1:0]   filter_in,
    input  logic                     acc_clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAPS*DATA_W-1:0]   ifmap,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         psum_out,
    output logic [CH_W-1:0]          ch_idx
);

    // state | meaning
    // ACCUM | accepting windows, accumulating channels
    // DRAIN | last beat accepted, waiting for it to leave stage 2
    // HOLD  | psum_out presented, waiting for out_ready
    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]   NUM_CH_EXT = (CH_W + 1)'(NUM_CH);
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        $signed({{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}});
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    state_t state, state_nxt;

    logic [TAPS*DATA_W-1:0] wb_mem [NUM_CH];
    logic [TAPS*DATA_W-1:0] cur_w;

    logic signed [2*DATA_W-1:0] prod_d [TAPS];
    logic signed [2*DATA_W-1:0] prod_q [TAPS];
    logic                       s1_valid, s1_first, s1_last;

    logic signed [ACC_W-1:0] tree_sum, acc_q, acc_next;
    logic [OUT_W-1:0]        psum_d;

    logic accept, clr_fire, ch_last;

    assign cur_w    = wb_mem[ch_idx];
    assign ch_last  = (ch_idx == LAST_CH);
    assign accept   = in_valid & in_ready & ~acc_clr;
    assign clr_fire = acc_clr & (state != HOLD);

    // Weight writes land at the clock edge, so a same-cycle accept still sees the old filter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) wb_mem[c] <= '0;
        end else if (wb_write_en && ({1'b0, wb_addr} < NUM_CH_EXT)) begin
            wb_mem[wb_addr] <= filter_in;
        end
    end

    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            prod_d[i] = (2*DATA_W)'($signed(ifmap[i*DATA_W +: DATA_W]))
                      * (2*DATA_W)'($signed(cur_w[i*DATA_W +: DATA_W]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_first <= (ch_idx == '0);
                s1_last  <= ch_last;
                for (int i = 0; i < TAPS; i++) prod_q[i] <= prod_d[i];
            end
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < TAPS; i++) tree_sum = tree_sum + ACC_W'(prod_q[i]);
    end

    assign acc_next = s1_first ? tree_sum : acc_q + tree_sum;

    always_comb begin
        psum_d = acc_next[OUT_W-1:0];
        if (SATURATE) begin
            if (acc_next > OUT_MAX)      psum_d = OUT_MAX[OUT_W-1:0];
            else if (acc_next < OUT_MIN) psum_d = OUT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ACCUM;
            ch_idx    <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            psum_out  <= '0;
        end else begin
            state <= state_nxt;
            if (clr_fire) begin
                ch_idx <= '0;
                acc_q  <= '0;
            end else begin
                if (accept) ch_idx <= ch_last ? '0 : ch_idx + 1'b1;
                if (s1_valid) acc_q <= acc_next;
            end
            if (s1_valid && s1_last && !clr_fire) begin
                out_valid <= 1'b1;
                psum_out  <= psum_d;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = rst;
                if (!clr_fire && accept && ch_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (clr_fire)                   state_nxt = ACCUM;
                else if (s1_valid && s1_last)   state_nxt = HOLD;
            end
            HOLD: begin
                if (out_valid && out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

endmodule

// File: tb/tb_pe_tensor_mc.sv
`timescale 1ns/1ps
// Bench for pe_tensor_mc: randomized and directed stimulus checked against a group-level
// accumulation model, with saturating, truncating and single-channel instances.
module tb_pe_tensor_mc;

    localparam int NC = 4;
    localparam int NT = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        wb_write_en, acc_clr, in_valid, out_ready;
    logic [1:0]  wb_addr;
    logic [71:0] filter_in, ifmap;
    logic        in_ready, out_valid, in_ready_t, out_valid_t;
    logic [15:0] psum_out, psum_t;
    logic [1:0]  ch_idx, ch_idx_t;

    logic        u_wen, u_valid, u_oready, u_in_ready, u_ov;
    logic [0:0]  u_addr, u_ch;
    logic [71:0] u_filter, u_ifmap;
    logic [15:0] u_psum;

    pe_tensor_mc #(.NUM_CH(4), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .wb_write_en(wb_write_en), .wb_addr(wb_addr),
        .filter_in(filter_in), .acc_clr(acc_clr), .in_valid(in_valid), .in_ready(in_ready),
        .ifmap(ifmap), .out_valid(out_valid), .out_ready(out_ready), .psum_out(psum_out),
        .ch_idx(ch_idx));

    pe_tensor_mc #(.NUM_CH(4), .SATURATE(1'b0)) dut_t (
        .clk(clk), .rst(rst), .wb_write_en(wb_write_en), .wb_addr(wb_addr),
        .filter_in(filter_in), .acc_clr(acc_clr), .in_valid(in_valid), .in_ready(in_ready_t),
        .ifmap(ifmap), .out_valid(out_valid_t), .out_ready(out_ready), .psum_out(psum_t),
        .ch_idx(ch_idx_t));

    pe_tensor_mc #(.NUM_CH(1)) dut_1 (
        .clk(clk), .rst(rst), .wb_write_en(u_wen), .wb_addr(u_addr),
        .filter_in(u_filter), .acc_clr(1'b0), .in_valid(u_valid), .in_ready(u_in_ready),
        .ifmap(u_ifmap), .out_valid(u_ov), .out_ready(u_oready), .psum_out(u_psum),
        .ch_idx(u_ch));

    int checks = 0;
    int errors = 0;

    // model: weights, pending channel contribution, group sum, presented result
    int     w [NC][NT];
    bit     m_busy, m_ov, p_valid, p_first, p_last;
    int     m_ch;
    longint m_acc, p_val, m_ps, m_pt;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint trunc16(input longint v);
        longint t;
        t = v & 64'hFFFF;
        if (t >= 32768) t -= 65536;
        return t;
    endfunction

    function automatic longint dot(input logic [71:0] win, input int ch);
        longint s = 0;
        for (int i = 0; i < NT; i++) s += longint'($signed(win[i*8 +: 8])) * longint'(w[ch][i]);
        return s;
    endfunction

    function automatic logic [71:0] fill(input int v);
        logic [71:0] r;
        for (int i = 0; i < NT; i++) r[i*8 +: 8] = 8'(v);
        return r;
    endfunction

    function automatic logic [71:0] rand_win();
        logic [71:0] r;
        for (int i = 0; i < NT; i++) r[i*8 +: 8] = 8'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) for (int i = 0; i < NT; i++) w[c][i] = 0;
        m_busy = 0; m_ov = 0; p_valid = 0; m_ch = 0; m_acc = 0; m_ps = 0; m_pt = 0;
    endtask

    task automatic model_edge();
        bit     acc_now;
        longint nv;
        acc_now = in_valid && !m_busy && !acc_clr;
        nv = acc_now ? dot(ifmap, m_ch) : 0;
        if (acc_clr && !m_ov) begin
            p_valid = 0; m_acc = 0; m_ch = 0; m_busy = 0;
        end else begin
            if (m_ov && out_ready) begin
                m_ov = 0; m_busy = 0;
            end
            if (p_valid) begin
                m_acc = p_first ? p_val : m_acc + p_val;
                if (p_last) begin
                    m_ov = 1; m_ps = sat16(m_acc); m_pt = trunc16(m_acc);
                end
                p_valid = 0;
            end
            if (acc_now) begin
                p_valid = 1; p_val = nv; p_first = (m_ch == 0); p_last = (m_ch == NC - 1);
                if (p_last) m_busy = 1;
                m_ch = (m_ch + 1) % NC;
            end
        end
        if (wb_write_en)
            for (int i = 0; i < NT; i++) w[wb_addr][i] = int'($signed(filter_in[i*8 +: 8]));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic wait_out(input int lim);
        bit ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            step();
            if (out_valid) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_out got no out_valid expected out_valid within %0d cycles", lim);
        end
    endtask

    task automatic idle();
        wb_write_en = 0; wb_addr = 0; filter_in = '0; acc_clr = 0;
        in_valid = 0; ifmap = '0; out_ready = 1;
    endtask

    task automatic write_all(input int v);
        for (int c = 0; c < NC; c++) begin
            wb_write_en = 1; wb_addr = 2'(c); filter_in = fill(v);
            step();
        end
        wb_write_en = 0;
    endtask

    always @(negedge clk) begin
        chk("in_ready", in_ready, rst && !m_busy);
        chk("in_ready_t", in_ready_t, rst && !m_busy);
        chk("ch_idx", ch_idx, m_ch);
        chk("out_valid", out_valid, m_ov);
        chk("out_valid_t", out_valid_t, m_ov);
        if (m_ov) begin
            chk("psum_sat", $signed(psum_out), m_ps);
            chk("psum_trunc", $signed(psum_t), m_pt);
        end
    end

    initial begin
        model_reset();
        idle();
        u_wen = 0; u_addr = 0; u_filter = '0; u_valid = 0; u_ifmap = '0; u_oready = 1;
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_psum", psum_out, 0);
        chk("rst_ch_idx", ch_idx, 0);
        chk("rst_u_in_ready", u_in_ready, 0);
        rst = 1;
        step();

        // single channel: taps 1..9 with unit weights
        u_wen = 1; u_filter = fill(1);
        step();
        u_wen = 0; u_valid = 1;
        for (int i = 0; i < NT; i++) u_ifmap[i*8 +: 8] = 8'(i + 1);
        step();
        u_valid = 0;
        chk("t1_ov_early", u_ov, 0);
        chk("t1_ready_drain", u_in_ready, 0);
        step();
        chk("t1_ov", u_ov, 1);
        chk("t1_psum", $signed(u_psum), 45);
        step();
        chk("t1_ov_after", u_ov, 0);
        chk("t1_ready_after", u_in_ready, 1);
        chk("t1_ch", u_ch, 0);

        // slot c weights c+1, windows of 2
        for (int c = 0; c < NC; c++) begin
            wb_write_en = 1; wb_addr = 2'(c); filter_in = fill(c + 1);
            step();
        end
        wb_write_en = 0;
        in_valid = 1; ifmap = fill(2);
        wait_out(20);
        chk("t2_psum", $signed(psum_out), 180);
        chk("t2_psum_t", $signed(psum_t), 180);
        in_valid = 0;
        step();
        chk("t2_ch", ch_idx, 0);

        // backpressure then a fresh group
        out_ready = 0; in_valid = 1; ifmap = fill(2);
        wait_out(20);
        ifmap = fill(3);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_hold_psum", $signed(psum_out), 180);
            chk("t3_hold_ready", in_ready, 0);
        end
        out_ready = 1; ifmap = fill(1);
        wait_out(20);
        chk("t3_next", $signed(psum_out), 90);

        // saturation and truncation extremes
        in_valid = 0;
        step();
        write_all(127);
        in_valid = 1; ifmap = fill(127);
        wait_out(20);
        chk("t4_pos_sat", $signed(psum_out), 32767);
        chk("t4_pos_trunc", $signed(psum_t), -9180);
        ifmap = fill(-128);
        wait_out(20);
        chk("t4_neg_sat", $signed(psum_out), -32768);
        chk("t4_neg_trunc", $signed(psum_t), 4608);
        in_valid = 0;
        step();

        // abort mid-group, then acc_clr while holding
        write_all(1);
        ifmap = fill(1); in_valid = 1;
        step(); step();
        acc_clr = 1;
        step();
        acc_clr = 0; out_ready = 0;
        wait_out(20);
        chk("t5_psum", $signed(psum_out), 36);
        in_valid = 0; acc_clr = 1;
        step();
        acc_clr = 0;
        chk("t5_hold_valid", out_valid, 1);
        chk("t5_hold_psum", $signed(psum_out), 36);
        out_ready = 1;
        step();

        // weight write colliding with a channel-0 accept
        in_valid = 1; ifmap = fill(1);
        wb_write_en = 1; wb_addr = 0; filter_in = fill(2);
        step();
        wb_write_en = 0;
        wait_out(20);
        chk("t6_old_w", $signed(psum_out), 36);
        wait_out(20);
        chk("t6_new_w", $signed(psum_out), 45);
        in_valid = 0;
        step();

        for (int n = 0; n < 600; n++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            ifmap       = rand_win();
            out_ready   = ($urandom_range(0, 9) < 7);
            acc_clr     = ($urandom_range(0, 19) == 0);
            wb_write_en = ($urandom_range(0, 7) == 0);
            wb_addr     = 2'($urandom_range(0, 3));
            filter_in   = rand_win();
            step();
        end

        // async reset while holding a result
        idle();
        out_ready = 0; in_valid = 1; ifmap = rand_win();
        wait_out(40);
        in_valid = 0;
        #3 rst = 0;
        model_reset();
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_psum", psum_out, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_ch", ch_idx, 0);
        step(); step();
        rst = 1;
        step();
        out_ready = 1; in_valid = 1; ifmap = fill(5);
        wait_out(20);
        chk("t6_w_cleared", $signed(psum_out), 0);
        in_valid = 0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
